// File: rtl/md5_pad.sv
// MD5 padding stage: turns a stream of 512-bit message beats into padded 512-bit blocks,
// appending the 0x80 marker, zero fill and the 64-bit little-endian bit length.
module md5_pad (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [63:0]  cfg_len,
  output logic         cfg_ready,
  input  logic         in_valid,
  input  logic [511:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [511:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic [63:0]  blocks_out
);

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StTailFull,
    StTailZero,
    StLen0,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [63:0]    lb_q, lb_d;       // message length in bits, mod 2^64
  logic [5:0]     r_q, r_d;         // bytes used in the final beat (0 = full beat)
  logic [57:0]    rem_q, rem_d;
  logic [63:0]    blocks_q, blocks_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic [511:0]   out_data_q, out_data_d;

  logic           ld;
  logic           hs;
  logic [57:0]    beats;

  // Keeps bytes below r, writes 0x80 at byte r, zeroes the rest; optionally
  // places the bit length in bytes 56..63.
  function automatic logic [511:0] pad_beat(input logic [511:0] d, input logic [5:0] r,
                                            input logic add_len, input logic [63:0] lb);
    logic [511:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(r)) begin
        o[8*i +: 8] = d[8*i +: 8];
      end else if (i == int'(r)) begin
        o[8*i +: 8] = 8'h80;
      end
    end
    if (add_len) begin
      o[511:448] = lb;
    end
    return o;
  endfunction

  assign ld    = !out_valid_q || out_ready;
  assign hs    = out_valid_q && out_ready;
  assign beats = cfg_len[63:6] + {57'd0, |cfg_len[5:0]};

  always_comb begin
    state_d     = state_q;
    lb_d        = lb_q;
    r_d         = r_q;
    rem_d       = rem_q;
    blocks_d    = hs ? blocks_q + 64'd1 : blocks_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    cfg_ready   = (state_q == StIdle);
    in_ready    = (state_q == StData) && ld;

    case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          lb_d     = {cfg_len[60:0], 3'b000};
          r_d      = cfg_len[5:0];
          rem_d    = beats;
          blocks_d = '0;
          state_d  = (cfg_len != 64'd0) ? StData : StLen0;
        end
      end
      StData: begin
        if (in_valid && ld) begin
          out_valid_d = 1'b1;
          if (rem_q != 58'd1 || r_q == 6'd0) begin
            out_data_d = in_data;
            out_last_d = 1'b0;
            rem_d      = rem_q - 58'd1;
            if (rem_q == 58'd1) begin
              state_d = StTailFull;
            end
          end else if (r_q < 6'd56) begin
            out_data_d = pad_beat(in_data, r_q, 1'b1, lb_q);
            out_last_d = 1'b1;
            state_d    = StDone;
          end else begin
            // No room for the length: it goes into an extra all-zero block.
            out_data_d = pad_beat(in_data, r_q, 1'b0, lb_q);
            out_last_d = 1'b0;
            state_d    = StTailZero;
          end
        end
      end
      StTailFull: begin
        if (ld) begin
          out_valid_d = 1'b1;
          out_data_d  = pad_beat('0, 6'd0, 1'b1, lb_q);
          out_last_d  = 1'b1;
          state_d     = StDone;
        end
      end
      StTailZero: begin
        if (ld) begin
          out_valid_d = 1'b1;
          out_data_d  = {lb_q, 448'd0};
          out_last_d  = 1'b1;
          state_d     = StDone;
        end
      end
      StLen0: begin
        if (ld) begin
          out_valid_d = 1'b1;
          out_data_d  = pad_beat('0, 6'd0, 1'b0, lb_q);
          out_last_d  = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (hs && out_last_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lb_q        <= '0;
      r_q         <= '0;
      rem_q       <= '0;
      blocks_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lb_q        <= lb_d;
      r_q         <= r_d;
      rem_q       <= rem_d;
      blocks_q    <= blocks_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;
  assign blocks_out = blocks_q;

endmodule

// File: tb/tb_md5_pad.sv
// Randomized scoreboard bench for md5_pad: a byte-level MD5 padding model produces the
// expected blocks; a monitor checks every output handshake, stalls and block counts.
module tb_md5_pad;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic [63:0]  cfg_len;
  logic         cfg_ready;
  logic         in_valid;
  logic [511:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [511:0] out_data;
  logic         out_last;
  logic         out_ready;
  logic [63:0]  blocks_out;

  md5_pad dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_len   (cfg_len),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .blocks_out(blocks_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [63:0]  idx;
  } exp_t;

  exp_t         sb[$];
  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  int           rdy_mode = 0;
  bit           in_tail = 1'b0;
  bit           chk_total = 1'b0;
  logic [63:0]  exp_total;
  bit           hold_valid = 1'b0;
  logic [511:0] held_data;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/none expected event", name);
  endtask

  // out_ready pattern: 0 = always high, 1 = alternate, 2 = random
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hold_valid = 1'b0;
      end else begin
        if (chk_total) begin
          chk("blocks_total", 512'(blocks_out), 512'(exp_total));
          chk_total = 1'b0;
        end
        if (hold_valid) begin
          chk("stall_valid", 512'(out_valid), 512'(1));
          chk("stall_data", out_data, held_data);
        end
        hold_valid = out_valid && !out_ready;
        held_data  = out_data;
        if (out_valid && !out_ready) chk("stall_in_ready", 512'(in_ready), 512'(0));
        if (in_tail) chk("post_final_in_ready", 512'(in_ready), 512'(0));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            fail("unexpected_block");
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("block_data", out_data, e.data);
            chk("block_last", 512'(out_last), 512'(e.last));
            chk("blocks_out", 512'(blocks_out), 512'(e.idx));
            if (e.last) begin
              chk_total = 1'b1;
              exp_total = e.idx + 64'd1;
            end
          end
        end
      end
    end
  end

  task automatic do_reset_check();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_valid = 1'b0;
    in_tail = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    chk_total = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_last", 512'(out_last), 512'(0));
    chk("rst_out_data", out_data, 512'(0));
    chk("rst_blocks_out", 512'(blocks_out), 512'(0));
    chk("rst_cfg_ready", 512'(cfg_ready), 512'(1));
    chk("rst_in_ready", 512'(in_ready), 512'(0));
  endtask

  // Sends one message; abort_after > 0 resets the DUT after that many beats.
  task automatic send_msg(input int len, input int mode, input int abort_after);
    logic [7:0]  msg[$];
    logic [7:0]  pad[$];
    logic [63:0] bits;
    int          nbeats;
    int          n;
    exp_t        e;
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) pad.push_back(bits[8*i +: 8]);
    for (int k = 0; k < pad.size() / 64; k++) begin
      for (int i = 0; i < 64; i++) e.data[8*i +: 8] = pad[64*k + i];
      e.last = (k == pad.size() / 64 - 1);
      e.idx  = 64'(k);
      sb.push_back(e);
    end
    rdy_mode = mode;

    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_len   = 64'(len);
    #1;
    n = 0;
    while (!cfg_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cfg_ready) begin
      fail("cfg_timeout");
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);

    nbeats = (len + 63) / 64;
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      in_tail   = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 64; i++)
        in_data[8*i +: 8] = (64*k + i < len) ? msg[64*k + i] : 8'($urandom);
      #1;
      n = 0;
      while (!in_ready && n < 2000) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (!in_ready) begin
        fail("beat_timeout");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (k + 1 == abort_after) begin
        do_reset_check();
        return;
      end
    end
    // Keep garbage beats on offer: none may be consumed after the final beat.
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = {16{$urandom}};
    in_tail   = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    do_reset_check();

    send_msg(0, 0, 0);
    send_msg(3, 0, 0);
    send_msg(64, 0, 0);
    send_msg(60, 0, 0);
    send_msg(200, 1, 0);
    send_msg(200, 1, 2);
    send_msg(3, 0, 0);
    send_msg(55, 2, 0);
    send_msg(56, 2, 0);
    send_msg(63, 2, 0);
    send_msg(119, 2, 0);
    send_msg(120, 2, 0);
    send_msg(128, 0, 0);
    for (int t = 0; t < 30; t++) begin
      send_msg(int'($urandom_range(0, 400)), int'($urandom_range(0, 2)), 0);
    end

    n = 0;
    while ((sb.size() != 0 || chk_total) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail("drain_timeout");
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md5_pad.md
Name: md5_pad

Overview:
- Upstream of the MD5 compression core: turns a raw message stream of 512-bit memory beats into MD5-padded 512-bit blocks.
- Input: beats popped from the read-data FIFO. Output: 512-bit chunks presented to the MD5 core input FIFO.
- Appends the 0x80 marker, zero fill and the 64-bit little-endian bit length, inserting an extra block when required.
- Message length is programmed per message through a one-shot config handshake.

Parameters:
- None; datapath fixed at 512 bits, length fixed at 64 bits.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  start a message; length on cfg_len
cfg_len  in  64  message length in bytes (L)
cfg_ready  out  1  high only in IDLE
in_valid  in  1  message beat available
in_data  in  512  message bytes; byte i at bits [8i+7:8i]
in_ready  out  1  beat accepted when in_valid && in_ready
out_valid  out  1  padded block valid
out_data  out  512  padded block, same byte order
out_last  out  1  marks final block of message
out_ready  in  1  downstream accept
blocks_out  out  64  blocks emitted for the current message

Behaviour:
- Reset: state IDLE; out_valid=0, out_last=0, out_data=0, blocks_out=0.
- Reset mid-message aborts: pending output is dropped and no further input is consumed.
- Output register:
  - Single output register; out_data/out_valid/out_last are held stable while out_valid && !out_ready.
  - Load enable: ld = !out_valid || out_ready.
- Derived values:
  - Beats needed: B = ceil(L/64).
  - r = L[5:0].
  - Bit length: LB = {L[60:0], 3'b0}, i.e. mod 2^64.
  - Remaining-beat counter is 58 bits.
- IDLE:
  - cfg_ready=1; in_ready=0.
  - On cfg_valid: latch L, set remaining=B, clear blocks_out.
  - Next state: DATA if B>0, else LEN0.
- DATA:
  - in_ready = ld.
  - Non-final beat (remaining>1), or final beat with r==0: load in_data unmodified into the output register and decrement remaining.
    - Final beat with r==0 goes to TAIL_FULL.
  - Final beat with 1<=r<=55:
    - Bytes [r-1:0] = input; byte r = 0x80; bytes r+1..55 = 0.
    - Bytes 56..63 = LB, little-endian.
    - Garbage input bytes >= r are masked.
    - Set out_last; next state DONE.
  - Final beat with 56<=r<=63: bytes [r-1:0] = input, byte r = 0x80, rest 0; next state TAIL_ZERO.
- TAIL_FULL: when ld, emit block with byte0=0x80, bytes1..55=0, bytes56..63=LB, out_last=1; next state DONE.
- TAIL_ZERO: when ld, emit block with bytes0..55=0, bytes56..63=LB, out_last=1; next state DONE.
- LEN0 (L==0): when ld, emit byte0=0x80, rest 0 (LB=0), out_last=1; next state DONE.
- DONE: stay until the last block handshakes (out_valid && out_ready && out_last), then go to IDLE.
  - cfg_valid is ignored until then.
- Throughput and latency:
  - One block per cycle with out_ready held high.
  - Latency: input beat to out_valid is 1 cycle.
- blocks_out increments on each out_valid && out_ready.
  - Total blocks per message = floor((L+8)/64)+1.
- cfg_valid is ignored outside IDLE.
- in_valid is ignored outside DATA; beats arriving after the final beat are not consumed.

Test Plan:
- L=0, out_ready=1 -> one block: byte0=0x80, all else 0, out_last=1; blocks_out=1.
- L=3, beat bytes 61 62 63 plus garbage -> one block: bytes0..3=61 62 63 80, byte56=0x18, rest 0, out_last=1.
- L=64 -> 2 blocks: data beat unchanged (out_last=0), then byte0=0x80, bytes56..57=00 02, out_last=1; blocks_out=2.
- L=60 -> 2 blocks: data bytes0..59, byte60=0x80, bytes61..63=0; then zeros with bytes56..57=E0 01, out_last=1.
- L=200 (4 beats) with out_ready toggling 1010…:
  - out_data stable while stalled; in_ready=0 when stalled.
  - 4 blocks total; last block byte8=0x80, bytes56..57=40 06.
- rst asserted after second beat of L=200 -> next cycle out_valid=0, state IDLE, cfg_ready=1; new L=3 message pads correctly.
